// File: rtl/display_frame_arbiter.sv
// ----------------------------------------------------------------------------
// display_frame_arbiter
//
// Shares one 8-digit seven-segment display between NUM_REQ message sources
// (game status, random number, score, ...). Each source offers a frame made of
// a 56-bit segment word (digit 7 at [55:49], digit 0 at [6:0], 1 = lit) and an
// 8-bit digit-enable mask (1 = digit on). The display is granted round-robin;
// a granted frame is latched and shown for DWELL cycles, optionally blinking
// with a half-period of BLINK_HALF cycles. Outputs feed the AN_In/C_In inputs
// of SevenSegmentLED.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_req        level request per source, held until done or withdrawn
//   i_seg_in     source i segment frame at [i*56 +: 56]
//   i_an_in      source i digit-enable mask at [i*8 +: 8]
//   i_blink_in   source i wants its frame blinked
//   o_gnt        one-hot grant, all-zero while idle
//   o_done       one-cycle pulse on the last dwell cycle of a completed frame
//   o_an_mask    digit-enable mask to the display driver
//   o_seg_frame  segment word to the display driver
//   o_busy       high while a frame is shown
// ----------------------------------------------------------------------------
module display_frame_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DWELL      = 100000000,
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [NUM_REQ*56-1:0]   i_seg_in,
    input  logic [NUM_REQ*8-1:0]    i_an_in,
    input  logic [NUM_REQ-1:0]      i_blink_in,
    output logic [NUM_REQ-1:0]      o_gnt,
    output logic [NUM_REQ-1:0]      o_done,
    output logic [7:0]              o_an_mask,
    output logic [55:0]             o_seg_frame,
    output logic                    o_busy
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
    // Second-to-last dwell count: the edge leaving it registers the done pulse.
    localparam logic [DW-1:0] DwellPen  = DW'(DWELL - 2);
    localparam logic [BW-1:0] BlinkLast = BW'(BLINK_HALF - 1);
    localparam logic [PW-1:0] PtrRst    = PW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShow
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e               r_state;
    logic [PW-1:0]        r_ptr;        // last winner; also the source being shown
    logic [DW-1:0]        r_dwell;
    logic [BW-1:0]        r_blink_cnt;
    logic                 r_phase;
    logic                 r_blink;
    logic [7:0]           r_an_lat;
    logic [55:0]          r_seg_frame;  // doubles as the latched segment word
    logic [7:0]           r_an_mask;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_busy;

    state_e               w_state_nxt;
    logic [PW-1:0]        w_ptr_nxt;
    logic [DW-1:0]        w_dwell_nxt;
    logic [BW-1:0]        w_blink_cnt_nxt;
    logic                 w_phase_nxt;
    logic                 w_blink_nxt;
    logic [7:0]           w_an_lat_nxt;
    logic [55:0]          w_seg_frame_nxt;
    logic [7:0]           w_an_mask_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [NUM_REQ-1:0]   w_done_nxt;
    logic                 w_busy_nxt;

    // Per-source views of the packed frame buses.
    logic [55:0]          w_seg_arr [NUM_REQ];
    logic [7:0]           w_an_arr  [NUM_REQ];

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_seg_arr[i] = i_seg_in[i*56 +: 56];
            w_an_arr[i]  = i_an_in[i*8 +: 8];
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: scan upward from the source after the last winner,
    // wrapping, so the most recent winner has the lowest priority.
    // ------------------------------------------------------------------------
    logic                 w_any;
    logic [PW-1:0]        w_win;

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(r_ptr) + k) % int'(NUM_REQ));
            if (!w_any && i_req[idx]) begin
                w_any = 1'b1;
                w_win = idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_dwell_nxt     = r_dwell;
        w_blink_cnt_nxt = r_blink_cnt;
        w_phase_nxt     = r_phase;
        w_blink_nxt     = r_blink;
        w_an_lat_nxt    = r_an_lat;
        w_seg_frame_nxt = r_seg_frame;
        w_an_mask_nxt   = r_an_mask;
        w_gnt_nxt       = r_gnt;
        w_done_nxt      = '0;
        w_busy_nxt      = r_busy;

        unique case (r_state)
            StIdle: begin
                w_gnt_nxt       = '0;
                w_seg_frame_nxt = '0;
                w_an_mask_nxt   = '0;
                w_busy_nxt      = 1'b0;
                if (w_any) begin
                    w_state_nxt      = StShow;
                    w_ptr_nxt        = w_win;
                    w_gnt_nxt[w_win] = 1'b1;
                    w_seg_frame_nxt  = w_seg_arr[w_win];
                    w_an_lat_nxt     = w_an_arr[w_win];
                    w_an_mask_nxt    = w_an_arr[w_win];
                    w_blink_nxt      = i_blink_in[w_win];
                    w_phase_nxt      = 1'b1;
                    w_dwell_nxt      = '0;
                    w_blink_cnt_nxt  = '0;
                    w_busy_nxt       = 1'b1;
                end
            end

            StShow: begin
                // Terminal cycle ends the frame whatever req does (done is
                // already out); an earlier drop of req is a withdrawal.
                if (r_dwell == DwellLast || !i_req[r_ptr]) begin
                    w_state_nxt     = StIdle;
                    w_gnt_nxt       = '0;
                    w_seg_frame_nxt = '0;
                    w_an_mask_nxt   = '0;
                    w_busy_nxt      = 1'b0;
                    w_dwell_nxt     = '0;
                    w_blink_cnt_nxt = '0;
                    w_phase_nxt     = 1'b0;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                    if (r_dwell == DwellPen) begin
                        w_done_nxt = r_gnt;
                    end
                    if (r_blink) begin
                        if (r_blink_cnt == BlinkLast) begin
                            w_blink_cnt_nxt = '0;
                            w_phase_nxt     = ~r_phase;
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                        end
                    end
                    w_an_mask_nxt = r_an_lat & {8{w_phase_nxt}};
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_ptr       <= PtrRst;
            r_dwell     <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_blink     <= 1'b0;
            r_an_lat    <= '0;
            r_seg_frame <= '0;
            r_an_mask   <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_dwell     <= w_dwell_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_blink     <= w_blink_nxt;
            r_an_lat    <= w_an_lat_nxt;
            r_seg_frame <= w_seg_frame_nxt;
            r_an_mask   <= w_an_mask_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_an_mask   = r_an_mask;
    assign o_seg_frame = r_seg_frame;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_display_frame_arbiter.sv
// ----------------------------------------------------------------------------
// tb_display_frame_arbiter
//
// Directed scenarios followed by random frames. Expected outputs come from a
// frame-level model: winner by round-robin search after the last winner,
// DWELL cycles of the latched frame, blink phase from the cycle number,
// done on the final cycle unless withdrawn earlier, then one blank cycle.
// ----------------------------------------------------------------------------
module tb_display_frame_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int BH = 2;

    localparam logic [6:0] SEG_ONE  = 7'b0000110;
    localparam logic [6:0] SEG_N    = 7'b1010100;
    localparam logic [6:0] SEG_P    = 7'b1110011;
    localparam logic [6:0] SEG_ZERO = 7'b0111111;

    logic           clk;
    logic           rst;
    logic [2:0]     req;
    logic [167:0]   seg;
    logic [23:0]    an;
    logic [2:0]     blink;
    logic [2:0]     gnt;
    logic [2:0]     done;
    logic [7:0]     an_mask;
    logic [55:0]    seg_frame;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int last;       // most recent winner, lowest round-robin priority

    display_frame_arbiter #(
        .NUM_REQ    (N),
        .DWELL      (DW),
        .BLINK_HALF (BH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_seg_in    (seg),
        .i_an_in     (an),
        .i_blink_in  (blink),
        .o_gnt       (gnt),
        .o_done      (done),
        .o_an_mask   (an_mask),
        .o_seg_frame (seg_frame),
        .o_busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_gnt"},  64'(gnt),       64'd0);
        chk({tag, "_done"}, 64'(done),      64'd0);
        chk({tag, "_an"},   64'(an_mask),   64'd0);
        chk({tag, "_seg"},  64'(seg_frame), 64'd0);
        chk({tag, "_busy"}, 64'(busy),      64'd0);
    endtask

    function automatic logic [167:0] rnd168();
        logic [167:0] v;
        v = '0;
        for (int i = 0; i < 7; i++) v[i*24 +: 24] = 24'($urandom);
        return v;
    endfunction

    // Starts in a blank idle cycle (#1 after an edge); ends in the blank
    // cycle after the frame, or right after raising rst at cycle abort_at.
    // wc: cycle during which the winner drops req (0 = never).
    // nz: scramble source inputs and other requests while the frame shows.
    task automatic run_frame(input logic [2:0] rq, input logic [167:0] s,
                             input logic [23:0] a, input logic [2:0] b,
                             input int wc, input int abort_at, input bit nz);
        int          w;
        int          len;
        bit          dn;
        logic [2:0]  oh;
        logic [55:0] es;
        logic [7:0]  em;
        logic [7:0]  ea;
        req   = rq;
        seg   = s;
        an    = a;
        blink = b;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (w < 0 && rq[idx]) w = idx;
        end
        if (w < 0) begin
            step();
            chk_blank("idle");
            return;
        end
        last = w;
        oh   = 3'(1 << w);
        es   = s[w*56 +: 56];
        em   = a[w*8 +: 8];
        len  = (wc >= 1 && wc < DW) ? wc : DW;
        dn   = (len == DW);
        step();
        for (int c = 1; c <= len; c++) begin
            ea = (b[w] && (((c - 1) / BH) % 2 == 1)) ? 8'h00 : em;
            chk("gnt",  64'(gnt),       64'(oh));
            chk("busy", 64'(busy),      64'd1);
            chk("seg",  64'(seg_frame), 64'(es));
            chk("an",   64'(an_mask),   64'(ea));
            chk("done", 64'(done),      (dn && c == DW) ? 64'(oh) : 64'd0);
            if (c == abort_at) begin
                rst = 1'b1;
                return;
            end
            if (nz) begin
                req   = 3'($urandom);
                seg   = rnd168();
                an    = 24'($urandom);
                blink = 3'($urandom);
            end
            req[w] = !(wc >= 1 && c >= wc);
            step();
        end
        chk_blank("gap");
    endtask

    logic [167:0] s0;

    initial begin
        // Reset held with all requests high.
        rst   = 1'b1;
        req   = 3'b111;
        seg   = '1;
        an    = '1;
        blink = '0;
        step();
        chk_blank("rst1");
        step();
        chk_blank("rst2");
        rst  = 1'b0;
        req  = 3'b000;
        last = N - 1;
        step();
        chk_blank("idle0");

        // Single frame from source 0.
        s0 = '0;
        s0[55:0] = {SEG_ONE, SEG_N, SEG_P, SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_P, SEG_ONE};
        run_frame(3'b001, s0, 24'h0000E3, 3'b000, 0, 0, 1'b0);

        // Fresh pointer, then all three requesting continuously.
        rst = 1'b1;
        step();
        chk_blank("rst3");
        rst  = 1'b0;
        last = N - 1;
        for (int i = 0; i < 4; i++) begin
            run_frame(3'b111, rnd168(), 24'($urandom), 3'b000, 0, 0, 1'b0);
        end

        // Blinking frame from source 1.
        run_frame(3'b010, rnd168(), 24'h00FF00, 3'b010, 0, 0, 1'b0);

        // Withdrawal on the third cycle, then input changes during a frame.
        run_frame(3'b001, rnd168(), 24'($urandom), 3'b000, 3, 0, 1'b0);
        run_frame(3'b001, rnd168(), 24'($urandom), 3'b001, 0, 0, 1'b1);

        // Withdrawal on the terminal cycle still completes.
        run_frame(3'b100, rnd168(), 24'($urandom), 3'b000, DW, 0, 1'b0);

        // Reset on the fourth cycle of source 2, then 101 after reset.
        run_frame(3'b100, rnd168(), 24'($urandom), 3'b000, 0, 4, 1'b0);
        req = 3'b101;
        step();
        chk_blank("rst_mid");
        rst  = 1'b0;
        last = N - 1;
        run_frame(3'b101, rnd168(), 24'($urandom), 3'b000, 0, 0, 1'b0);

        // Random frames.
        for (int i = 0; i < 40; i++) begin
            run_frame(3'($urandom), rnd168(), 24'($urandom), 3'($urandom),
                      int'($urandom_range(0, 12)), 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
